muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 40, maximum WAIT cycles before a watchdog exception; legal range 2..255.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 op_valid  input  1  request to start an operation; sampled only in IDLE.
REQ-005 op_sel  input  1  operation select: 0 = multiplier, 1 = divisor; sampled with op_valid.
REQ-006 abort  input  1  cancel the operation in progress.
REQ-007 mult_fim  input  1  multiplier finished.
REQ-008 div_fim  input  1  divisor finished.
REQ-009 div_by_zero  input  1  divisor reports zero divisor.
REQ-010 op_ready  output  1  high only in IDLE.
REQ-011 mult_start  output  1  one-cycle start pulse to multiplier.
REQ-012 div_start  output  1  one-cycle start pulse to divisor.
REQ-013 hi_sel  output  1  HI source mux select (0 mult, 1 div).
REQ-014 lo_sel  output  1  LO source mux select (0 mult, 1 div).
REQ-015 hi_write, lo_write  output  1 each  HI/LO register write enables.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 div_zero_exc  output  1  one-cycle divide-by-zero exception pulse.
REQ-018 timeout_exc  output  1  one-cycle watchdog exception pulse.
REQ-019 state  output  3  current state: IDLE=0, START=1, WAIT=2, WRITE=3, DONE=4, EXC=5.

Function
REQ-020 IDLE: op_ready=1; op_valid=1 latches op_sel into op_reg and moves to START; otherwise stays in IDLE.
REQ-021 START: asserts mult_start (op_reg=0) or div_start (op_reg=1) for exactly this cycle; clears wait counter to 0; moves to WAIT.
REQ-022 WAIT: increments wait counter every cycle; the counter value is 0 in the first WAIT cycle.
REQ-023 WAIT, op_reg=1, div_by_zero=1: moves to EXC with cause divide-by-zero, regardless of div_fim.
REQ-024 WAIT, fim of the selected unit=1 (and no REQ-023 condition): moves to WRITE.
REQ-025 WAIT: the fim of the non-selected unit is ignored; div_by_zero is ignored when op_reg=0.
REQ-026 WAIT, counter = TIMEOUT-1 with no fim and no div_by_zero: moves to EXC with cause timeout; a fim in that same cycle takes priority and moves to WRITE.
REQ-027 WRITE: hi_write=lo_write=1 for exactly one cycle; moves to DONE.
REQ-028 DONE: done=1 for one cycle; moves to IDLE; a new op_valid is accepted no earlier than the following (IDLE) cycle.
REQ-029 EXC: asserts exactly one of div_zero_exc or timeout_exc, per the latched cause, for one cycle; no HI/LO write; moves to IDLE.
REQ-030 abort=1 in START, WAIT or EXC moves to IDLE next cycle, suppressing pending writes and exception pulses for that cycle onward.
REQ-031 abort is ignored in IDLE, WRITE and DONE; the write/done sequence always completes.
REQ-032 hi_sel=lo_sel=op_reg and are held constant from START through DONE/EXC; op_reg does not change outside IDLE.
REQ-033 All outputs are registered or decoded solely from state and op_reg, with no combinational path from inputs to outputs.
REQ-034 Wait counter width is 8 bits, saturates at 255, and never wraps.
REQ-035 Unused state encodings (6, 7) return to IDLE on the next clock.

Reset
REQ-036 reset=0 asynchronously forces state=IDLE, op_reg=0, counter=0, cause=0; all outputs read 0 except op_ready=1.
REQ-037 reset asserted mid-operation aborts it with no write, done or exception pulse; the first cycle after release is IDLE.

Verification
REQ-038 op_valid=1, op_sel=0 in IDLE; mult_fim=1 on 5th WAIT cycle -> mult_start 1 cycle, hi/lo_write 1 cycle with sel=0, done 1 cycle, back to IDLE.
REQ-039 op_sel=1, div_by_zero=1 and div_fim=1 simultaneously on 3rd WAIT cycle -> div_zero_exc 1 cycle, hi/lo_write never asserted.
REQ-040 TIMEOUT=4, op_sel=0, no mult_fim -> timeout_exc asserted exactly 1 cycle after the 4th WAIT cycle; mult_fim=1 on the 4th WAIT cycle instead -> WRITE, no exception.
REQ-041 op_sel=0, div_fim=1 during WAIT -> ignored, remains in WAIT until mult_fim or timeout.
REQ-042 abort=1 in 2nd WAIT cycle -> IDLE next cycle, no done/write/exception; abort=1 in WRITE -> write and done still occur.
REQ-043 reset=0 pulsed asynchronously between clock edges during WAIT -> outputs immediately at reset values, op_ready=1 after release.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Bundle of request, status and control signals between the multiply/divide
// sequencer and its surroundings (issuing pipeline plus the two arithmetic units).
//
// Handshake: an operation is accepted on a rising clock edge where op_valid=1
// and op_ready=1 (op_ready is high only while the sequencer is idle). op_sel
// travels with op_valid. op_valid is ignored whenever op_ready=0, so the
// requester may hold or drop it freely while the sequencer is busy.
interface muldiv_sequencer_if;
   // requester / arithmetic-unit side
   logic       op_valid;
   logic       op_sel;
   logic       abort;
   logic       mult_fim;
   logic       div_fim;
   logic       div_by_zero;
   // sequencer side
   logic       op_ready;
   logic       mult_start;
   logic       div_start;
   logic       hi_sel;
   logic       lo_sel;
   logic       hi_write;
   logic       lo_write;
   logic       done;
   logic       div_zero_exc;
   logic       timeout_exc;
   logic [2:0] state;

   // Environment that issues operations and hosts the arithmetic units
   modport master (
      output op_valid, op_sel, abort, mult_fim, div_fim, div_by_zero,
      input  op_ready, mult_start, div_start, hi_sel, lo_sel,
             hi_write, lo_write, done, div_zero_exc, timeout_exc, state
   );

   // The sequencer itself
   modport slave (
      input  op_valid, op_sel, abort, mult_fim, div_fim, div_by_zero,
      output op_ready, mult_start, div_start, hi_sel, lo_sel,
             hi_write, lo_write, done, div_zero_exc, timeout_exc, state
   );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multiply/divide sequencer: launches the selected arithmetic unit, waits for
// its finish flag under a watchdog, then writes HI/LO and signals completion,
// or raises a divide-by-zero / timeout exception. Every output is a register,
// so nothing on the input side reaches an output in the same cycle.
module muldiv_sequencer #(
   // Maximum number of WAIT cycles before the watchdog fires (legal 2..255)
   parameter int unsigned TIMEOUT = 40
) (
   input  logic               clock,
   input  logic               reset,
   muldiv_sequencer_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      WAIT  = 3'd2,
      WRITE = 3'd3,
      DONE  = 3'd4,
      EXC   = 3'd5
   } stateT;

   // Counter value seen in the last WAIT cycle the watchdog allows
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   stateT      stateQ;
   logic       opReg;        // 0 = multiplier, 1 = divisor
   logic [7:0] waitCnt;      // WAIT cycles elapsed, saturating
   logic       causeDivZero; // 1 = divide-by-zero, 0 = timeout
   logic       opReadyQ;
   logic       multStartQ;
   logic       divStartQ;
   logic       writeQ;
   logic       doneQ;
   logic       divZeroExcQ;
   logic       timeoutExcQ;

   // Finish flag of the unit this operation is using; the other one is ignored
   logic selFim;
   assign selFim = opReg ? bus.div_fim : bus.mult_fim;

   // Sequencer FSM; each transition also loads the outputs of the state it enters
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stateQ       <= IDLE;
         opReg        <= 1'b0;
         waitCnt      <= 8'd0;
         causeDivZero <= 1'b0;
         opReadyQ     <= 1'b1;
         multStartQ   <= 1'b0;
         divStartQ    <= 1'b0;
         writeQ       <= 1'b0;
         doneQ        <= 1'b0;
         divZeroExcQ  <= 1'b0;
         timeoutExcQ  <= 1'b0;
      end else begin
         // pulse outputs default low; the branch below raises the one owed
         opReadyQ    <= 1'b0;
         multStartQ  <= 1'b0;
         divStartQ   <= 1'b0;
         writeQ      <= 1'b0;
         doneQ       <= 1'b0;
         divZeroExcQ <= 1'b0;
         timeoutExcQ <= 1'b0;

         case (stateQ)
            IDLE: begin
               if (bus.op_valid) begin
                  stateQ     <= START;
                  opReg      <= bus.op_sel;
                  multStartQ <= ~bus.op_sel;
                  divStartQ  <= bus.op_sel;
               end else begin
                  opReadyQ <= 1'b1;
               end
            end

            START: begin
               waitCnt <= 8'd0;
               if (bus.abort) begin
                  stateQ   <= IDLE;
                  opReadyQ <= 1'b1;
               end else begin
                  stateQ <= WAIT;
               end
            end

            WAIT: begin
               if (waitCnt != 8'hFF) begin
                  waitCnt <= waitCnt + 8'd1;
               end
               // abort > divide-by-zero > finish > watchdog
               if (bus.abort) begin
                  stateQ   <= IDLE;
                  opReadyQ <= 1'b1;
               end else if (opReg && bus.div_by_zero) begin
                  stateQ       <= EXC;
                  causeDivZero <= 1'b1;
                  divZeroExcQ  <= 1'b1;
               end else if (selFim) begin
                  stateQ <= WRITE;
                  writeQ <= 1'b1;
               end else if (waitCnt == LAST_WAIT) begin
                  stateQ       <= EXC;
                  causeDivZero <= 1'b0;
                  timeoutExcQ  <= 1'b1;
               end
            end

            // abort is ignored here: the write/done sequence always completes
            WRITE: begin
               stateQ <= DONE;
               doneQ  <= 1'b1;
            end

            DONE: begin
               stateQ   <= IDLE;
               opReadyQ <= 1'b1;
            end

            // the exception pulse is already on the outputs; abort changes nothing
            EXC: begin
               stateQ   <= IDLE;
               opReadyQ <= 1'b1;
            end

            // encodings 6 and 7 recover to IDLE
            default: begin
               stateQ   <= IDLE;
               opReadyQ <= 1'b1;
            end
         endcase
      end
   end

   assign bus.op_ready     = opReadyQ;
   assign bus.mult_start   = multStartQ;
   assign bus.div_start    = divStartQ;
   assign bus.hi_sel       = opReg;
   assign bus.lo_sel       = opReg;
   assign bus.hi_write     = writeQ;
   assign bus.lo_write     = writeQ;
   assign bus.done         = doneQ;
   assign bus.div_zero_exc = divZeroExcQ;
   assign bus.timeout_exc  = timeoutExcQ;
   assign bus.state        = stateQ;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: two instances (default watchdog and a short one
// of 4 cycles) driven by directed and randomized operations. For every
// operation the outcome is worked out up front from the event indices
// (first of abort / divide-by-zero / finish / watchdog, with their priority),
// then the expected per-cycle output trace is compared against each DUT.
module tb_muldiv_sequencer;

   localparam int TO_A = 40;
   localparam int TO_B = 4;

   logic clock;
   logic reset;

   logic [1:0] opValid, opSel, abortIn, multFim, divFim, dbz;

   muldiv_sequencer_if busA ();
   muldiv_sequencer_if busB ();

   assign busA.op_valid    = opValid[0];
   assign busA.op_sel      = opSel[0];
   assign busA.abort       = abortIn[0];
   assign busA.mult_fim    = multFim[0];
   assign busA.div_fim     = divFim[0];
   assign busA.div_by_zero = dbz[0];
   assign busB.op_valid    = opValid[1];
   assign busB.op_sel      = opSel[1];
   assign busB.abort       = abortIn[1];
   assign busB.mult_fim    = multFim[1];
   assign busB.div_fim     = divFim[1];
   assign busB.div_by_zero = dbz[1];

   muldiv_sequencer #(.TIMEOUT(TO_A)) dutA (.clock(clock), .reset(reset), .bus(busA));
   muldiv_sequencer #(.TIMEOUT(TO_B)) dutB (.clock(clock), .reset(reset), .bus(busB));

   // {state, op_ready, mult_start, div_start, hi_sel, lo_sel, hi_write, lo_write, done, div_zero_exc, timeout_exc}
   logic [12:0] obs [2];
   assign obs[0] = {busA.state, busA.op_ready, busA.mult_start, busA.div_start, busA.hi_sel,
                    busA.lo_sel, busA.hi_write, busA.lo_write, busA.done, busA.div_zero_exc,
                    busA.timeout_exc};
   assign obs[1] = {busB.state, busB.op_ready, busB.mult_start, busB.div_start, busB.hi_sel,
                    busB.lo_sel, busB.hi_write, busB.lo_write, busB.done, busB.div_zero_exc,
                    busB.timeout_exc};

   int checks = 0;
   int errors = 0;
   bit lastSel [2];

   // clock / reset
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // Outputs the specification defines for a given phase
   function automatic logic [12:0] ev(logic [2:0] st, bit sel, bit dzCause);
      bit isStart = (st == 3'd1);
      bit isExc   = (st == 3'd5);
      return {st, st == 3'd0, isStart && !sel, isStart && sel, sel, sel,
              st == 3'd3, st == 3'd3, st == 3'd4, isExc && dzCause, isExc && !dzCause};
   endfunction

   task automatic chk(int d, logic [12:0] e, string tag);
      checks++;
      assert (obs[d] === e) else begin
         errors++;
         $error("FAIL %s dut%0d observed %h expected %h", tag, d, obs[d], e);
      end
   endtask

   task automatic drive(int d, bit v, bit s, bit ab, bit mf, bit df, bit dz);
      opValid[d] = v;
      opSel[d]   = s;
      abortIn[d] = ab;
      multFim[d] = mf;
      divFim[d]  = df;
      dbz[d]     = dz;
   endtask

   // One cycle: check outputs of the current state, then set inputs for this cycle
   task automatic cyc(int d, logic [12:0] e, string tag, bit v, bit s, bit ab, bit mf, bit df, bit dz);
      @(negedge clock);
      chk(d, e, tag);
      drive(d, v, s, ab, mf, df, dz);
   endtask

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // One operation. Indices count WAIT cycles from 0; -1 means the event never happens.
   task automatic run_op(int d, bit sel, int fimAt, int otherAt, int dzAt, int abAt,
                         bit abStart, bit abLate, bit noise);
      int t = (d == 0) ? TO_A : TO_B;
      int endK;
      int why; // 0 abort, 1 divide-by-zero, 2 finish, 3 watchdog
      cyc(d, ev(3'd0, lastSel[d], 1'b0), "idle_accept", 1'b1, sel, 1'b0, 1'b0, 1'b0, 1'b0);
      lastSel[d] = sel;
      cyc(d, ev(3'd1, sel, 1'b0), "start", noise & rb(), noise & rb(), abStart, 1'b0, 1'b0, 1'b0);
      if (abStart) begin
         cyc(d, ev(3'd0, sel, 1'b0), "abort_start_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
         return;
      end
      endK = t - 1;
      why  = 3;
      if (fimAt >= 0 && fimAt <= endK) begin endK = fimAt; why = 2; end
      if (sel && dzAt >= 0 && dzAt <= endK) begin endK = dzAt; why = 1; end
      if (abAt >= 0 && abAt <= endK) begin endK = abAt; why = 0; end
      for (int k = 0; k <= endK; k++) begin
         cyc(d, ev(3'd2, sel, 1'b0), "wait", noise & rb(), noise & rb(), k == abAt,
             sel ? (k == otherAt) : (k == fimAt), sel ? (k == fimAt) : (k == otherAt), k == dzAt);
      end
      case (why)
         0: ;
         1: begin
            cyc(d, ev(3'd5, sel, 1'b1), "exc_div_zero", noise & rb(), noise & rb(), abLate, 1'b0, 1'b0, 1'b0);
         end
         2: begin
            cyc(d, ev(3'd3, sel, 1'b0), "write", noise & rb(), noise & rb(), abLate, 1'b0, 1'b0, 1'b0);
            cyc(d, ev(3'd4, sel, 1'b0), "done", noise & rb(), noise & rb(), abLate, 1'b0, 1'b0, 1'b0);
         end
         default: begin
            cyc(d, ev(3'd5, sel, 1'b0), "exc_timeout", noise & rb(), noise & rb(), abLate, 1'b0, 1'b0, 1'b0);
         end
      endcase
      cyc(d, ev(3'd0, sel, 1'b0), "back_to_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int d, t, fimAt, otherAt, dzAt, abAt;
      bit sel, abStart, abLate;
      reset = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      lastSel[0] = 1'b0;
      lastSel[1] = 1'b0;
      repeat (2) @(negedge clock);
      chk(0, ev(3'd0, 1'b0, 1'b0), "reset_state");
      chk(1, ev(3'd0, 1'b0, 1'b0), "reset_state");
      #2 reset = 1'b1;

      // multiply, finish on 5th WAIT cycle
      run_op(0, 1'b0, 4, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      // divide with divide-by-zero and finish together on 3rd WAIT cycle
      run_op(0, 1'b1, 2, -1, 2, -1, 1'b0, 1'b0, 1'b0);
      // short watchdog: timeout, then finish on the last allowed WAIT cycle
      run_op(1, 1'b0, -1, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      run_op(1, 1'b0, 3, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      run_op(1, 1'b1, 3, -1, -1, -1, 1'b0, 1'b0, 1'b0);
      // finish of the other unit ignored
      run_op(0, 1'b0, 10, 3, -1, -1, 1'b0, 1'b0, 1'b0);
      run_op(1, 1'b0, -1, 1, -1, -1, 1'b0, 1'b0, 1'b0);
      // divide-by-zero ignored during a multiply
      run_op(0, 1'b0, 5, -1, 2, -1, 1'b0, 1'b0, 1'b0);
      // plain divide
      run_op(0, 1'b1, 6, 2, -1, -1, 1'b0, 1'b0, 1'b0);
      // abort in 2nd WAIT cycle, abort in START, abort together with finish
      run_op(0, 1'b0, 8, -1, -1, 1, 1'b0, 1'b0, 1'b0);
      run_op(0, 1'b1, 3, -1, -1, -1, 1'b1, 1'b0, 1'b0);
      run_op(0, 1'b1, 3, -1, -1, 3, 1'b0, 1'b0, 1'b0);
      // abort in WRITE/DONE and in EXC is ignored
      run_op(0, 1'b0, 2, -1, -1, -1, 1'b0, 1'b1, 1'b0);
      run_op(1, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1, 1'b0);

      // asynchronous reset pulsed between clock edges in WAIT
      cyc(0, ev(3'd0, lastSel[0], 1'b0), "rst_accept", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      lastSel[0] = 1'b1;
      cyc(0, ev(3'd1, 1'b1, 1'b0), "rst_start", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(0, ev(3'd2, 1'b1, 1'b0), "rst_wait0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(0, ev(3'd2, 1'b1, 1'b0), "rst_wait1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      lastSel[0] = 1'b0;
      lastSel[1] = 1'b0;
      chk(0, ev(3'd0, 1'b0, 1'b0), "async_reset_now");
      chk(1, ev(3'd0, 1'b0, 1'b0), "async_reset_now");
      @(negedge clock);
      chk(0, ev(3'd0, 1'b0, 1'b0), "reset_held");
      #2 reset = 1'b1;
      cyc(0, ev(3'd0, 1'b0, 1'b0), "post_reset_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(0, ev(3'd0, 1'b0, 1'b0), "post_reset_idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      run_op(0, 1'b0, 1, -1, -1, -1, 1'b0, 1'b0, 1'b0);

      // randomized operations with input noise in busy cycles
      for (int n = 0; n < 60; n++) begin
         d   = int'($urandom_range(0, 1));
         t   = (d == 0) ? TO_A : TO_B;
         sel = rb();
         fimAt = -1;
         if ($urandom_range(0, 4) != 0) fimAt = int'($urandom_range(0, t + 1));
         otherAt = int'($urandom_range(0, t));
         dzAt = -1;
         if ($urandom_range(0, 2) == 0) dzAt = int'($urandom_range(0, t));
         abAt = -1;
         if ($urandom_range(0, 5) == 0) abAt = int'($urandom_range(0, t));
         abStart = ($urandom_range(0, 9) == 0);
         abLate  = rb();
         run_op(d, sel, fimAt, otherAt, dzAt, abAt, abStart, abLate, 1'b1);
         for (int g = int'($urandom_range(0, 2)); g > 0; g--) begin
            cyc(d, ev(3'd0, lastSel[d], 1'b0), "idle_gap", 1'b0, rb(), rb(), rb(), rb(), rb());
         end
         drive(d, 0, 0, 0, 0, 0, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
